// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared state encoding and counter width for the mux2 arbiter
package mux2_arb_pkg;
  localparam int HOLD_CNT_W = 8;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;
endpackage

// File: rtl/mux2.sv
// mux2: single-bit two-input multiplexer
module mux2 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin two-requester arbiter owning a mux2 datapath select
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic [1:0]       gnt,
  output logic             sel,
  output logic [WIDTH-1:0] z
);
  localparam logic [HOLD_CNT_W-1:0] LIM = HOLD_CNT_W'(MAX_HOLD - 1);
  arb_state_t            state_q, state_d;
  logic                  last_q, last_d;
  logic [HOLD_CNT_W-1:0] cnt_q, cnt_d;
  logic                  mine, oth, tmo, entry;
  logic [WIDTH-1:0]      y;
  // next state, last-served flag and hold counter
  always_comb begin
    mine    = state_q[1] ? req[1] : req[0];
    oth     = state_q[1] ? req[0] : req[1];
    tmo     = (MAX_HOLD != 0) && oth && (cnt_q == LIM);
    state_d = (state_q == IDLE) ? ((req == 2'b11) ? (last_q ? GNT0 : GNT1) :
                                   req[0] ? GNT0 : req[1] ? GNT1 : IDLE) :
              (state_q == GNT0 || state_q == GNT1) ?
                ((mine && !tmo) ? state_q : oth ? ((state_q == GNT0) ? GNT1 : GNT0) : IDLE) :
              IDLE;
    entry   = (state_d != state_q) && (state_d != IDLE);
    last_d  = entry ? (state_d == GNT1) : last_q;
    cnt_d   = entry ? '0 : (state_q == IDLE) ? cnt_q :
              oth ? ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1) : '0;
  end
  // state register; the state encoding doubles as the registered grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  assign gnt = state_q;
  assign sel = state_q[1];
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux2 u_mux (.a(d0[i]), .b(d1[i]), .sel(sel), .y(y[i]));
  end
  assign z = (gnt != 2'b00) ? y : '0;
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: directed table-driven check of mux2_arbiter
module tb_mux2_arbiter;
  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [1:0] gnt;
    logic [3:0] z;
  } vec_t;
  logic       clk = 0;
  logic       rst_a = 1, rst_b = 1;
  logic [1:0] req_a = 0, req_b = 0;
  logic [3:0] d0 = 0, d1 = 0;
  logic [1:0] gnt_a, gnt_b;
  logic       sel_a, sel_b;
  logic [3:0] z_a, z_b;
  int checks = 0, errs = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  mux2_arbiter #(.WIDTH(4), .MAX_HOLD(4)) dut_a (
    .clk(clk), .reset(rst_a), .req(req_a), .d0(d0), .d1(d1),
    .gnt(gnt_a), .sel(sel_a), .z(z_a));
  mux2_arbiter #(.WIDTH(4), .MAX_HOLD(0)) dut_b (
    .clk(clk), .reset(rst_b), .req(req_b), .d0(d0), .d1(d1),
    .gnt(gnt_b), .sel(sel_b), .z(z_b));
  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [1:0] q, input logic [3:0] a, input logic [3:0] b,
                     input logic [1:0] g, input logic [3:0] zz);
    tbl.push_back('{r, q, a, b, g, zz});
  endtask
  always @(negedge clk) begin
    if (!rst_a) chk("onehot_a", 0, {7'd0, gnt_a == 2'b11}, 8'd0);
    if (!rst_b) chk("onehot_b", 0, {7'd0, gnt_b == 2'b11}, 8'd0);
  end
  initial begin
    add(1, 2'b00, 4'h5, 4'hA, 2'b00, 4'h0);
    add(0, 2'b01, 4'h1, 4'h0, 2'b01, 4'h1);
    add(0, 2'b00, 4'h1, 4'h0, 2'b00, 4'h0);
    add(0, 2'b10, 4'h3, 4'hC, 2'b10, 4'hC);
    add(0, 2'b01, 4'h3, 4'hC, 2'b01, 4'h3);
    add(0, 2'b10, 4'h3, 4'hC, 2'b10, 4'hC);
    add(0, 2'b00, 4'h3, 4'hC, 2'b00, 4'h0);
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++)
        add(0, 2'b11, 4'h3, 4'hC, (r == 1) ? 2'b10 : 2'b01, (r == 1) ? 4'hC : 4'h3);
    for (int k = 0; k < 21; k++) add(0, 2'b10, 4'h6, 4'h9, 2'b10, 4'h9);
    add(0, 2'b11, 4'h6, 4'h9, 2'b10, 4'h9);
    add(1, 2'b11, 4'h6, 4'h9, 2'b00, 4'h0);
    add(0, 2'b11, 4'h6, 4'h9, 2'b01, 4'h6);
    add(0, 2'b11, 4'h6, 4'h9, 2'b01, 4'h6);
    foreach (tbl[i]) begin
      @(negedge clk);
      rst_a = tbl[i].rst; req_a = tbl[i].req; d0 = tbl[i].d0; d1 = tbl[i].d1;
      @(posedge clk); #1;
      chk("gnt", i, {6'd0, gnt_a}, {6'd0, tbl[i].gnt});
      chk("sel", i, {7'd0, sel_a}, {7'd0, tbl[i].gnt[1]});
      chk("z", i, {4'd0, z_a}, {4'd0, tbl[i].z});
    end
    @(negedge clk);
    req_a = 2'b00; rst_b = 1; req_b = 2'b11; d0 = 4'h7; d1 = 4'hE;
    @(posedge clk); #1;
    chk("b_reset", 0, {6'd0, gnt_b}, 8'd0);
    @(negedge clk); rst_b = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      chk("b_hold_gnt", k, {6'd0, gnt_b}, 8'd1);
      chk("b_hold_z", k, {4'd0, z_b}, 8'h07);
    end
    @(negedge clk); req_b = 2'b10;
    @(posedge clk); #1;
    chk("b_release_gnt", 0, {6'd0, gnt_b}, 8'd2);
    chk("b_release_sel", 0, {7'd0, sel_b}, 8'd1);
    chk("b_release_z", 0, {4'd0, z_b}, 8'h0E);
    @(negedge clk); req_b = 2'b00;
    @(posedge clk); #1;
    chk("b_idle", 0, {6'd0, gnt_b}, 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
